// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller between the cpu byte port and a word-wide data_memory.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module dcache_controller #(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
    ,
    output logic [15:0] HIT_COUNT,
    output logic [15:0] MISS_COUNT
`endif
);

    localparam int INDEX_W  = $clog2(NUM_BLOCKS);
    localparam int OFFSET_W = $clog2(BLOCK_BYTES);
    localparam int TAG_W    = 8 - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {IDLE, WRITE_BACK, FETCH, REFILL} state_t;

    state_t state, next_state;
    logic   armed;

    logic [31:0]      data_arr [NUM_BLOCKS];
    logic [TAG_W-1:0] tag_arr  [NUM_BLOCKS];
    logic [NUM_BLOCKS-1:0] valid, dirty;

    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  index;
    logic [OFFSET_W-1:0] offset;
    logic                access, hit;

    assign tag    = ADDRESS[7 -: TAG_W];
    assign index  = ADDRESS[OFFSET_W +: INDEX_W];
    assign offset = ADDRESS[OFFSET_W-1:0];
    assign access = READ | WRITE;

    always_comb begin
        hit = 1'b0;
        if (state == IDLE && !RESET)
            hit = valid[index] && (tag_arr[index] == tag);
    end

    // armed marks that at least one full cycle has been spent in a memory state
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= next_state;
            armed <= (state == WRITE_BACK || state == FETCH) && (next_state == state);
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:
                if (access && !hit)
                    next_state = (valid[index] && dirty[index]) ? WRITE_BACK : FETCH;
            WRITE_BACK:
                if (armed && !MEM_BUSYWAIT) next_state = FETCH;
            FETCH:
                if (armed && !MEM_BUSYWAIT) next_state = REFILL;
            REFILL:
                next_state = IDLE;
            default:
                next_state = IDLE;
        endcase
    end

    always_comb begin
        MEM_READ      = 1'b0;
        MEM_WRITE     = 1'b0;
        MEM_ADDRESS   = '0;
        MEM_WRITEDATA = '0;
        READDATA      = '0;
        BUSYWAIT      = 1'b0;
        unique case (state)
            WRITE_BACK: begin
                MEM_WRITE     = 1'b1;
                MEM_ADDRESS   = {tag_arr[index], index};
                MEM_WRITEDATA = data_arr[index];
            end
            FETCH: begin
                MEM_READ    = 1'b1;
                MEM_ADDRESS = ADDRESS[7:2];
            end
            default: ;
        endcase
        if (READ && !WRITE && hit)
            READDATA = data_arr[index][{offset, 3'b000} +: 8];
        // reset forces the stall low even while the cpu still requests
        if (!RESET)
            BUSYWAIT = (state != IDLE) || (access && !hit);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (state == REFILL) begin
            valid[index] <= 1'b1;
            dirty[index] <= 1'b0;
        end else if (hit && WRITE) begin
            dirty[index] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (state == REFILL) begin
            data_arr[index] <= MEM_READDATA;
            tag_arr[index]  <= tag;
        end else if (hit && WRITE) begin
            data_arr[index][{offset, 3'b000} +: 8] <= WRITEDATA;
        end
    end

`ifdef DCACHE_STATS_EN
    logic post_refill;

    // the hit that follows a refill belongs to an access already counted as a miss
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            post_refill <= 1'b0;
            HIT_COUNT   <= '0;
            MISS_COUNT  <= '0;
        end else begin
            post_refill <= (state == REFILL);
            if (access && hit && !post_refill && HIT_COUNT != '1)
                HIT_COUNT <= HIT_COUNT + 16'd1;
            if (state == IDLE && access && !hit && MISS_COUNT != '1)
                MISS_COUNT <= MISS_COUNT + 16'd1;
        end
    end
`endif

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back data cache controller between the cpu load/store port and data_memory.
- Answers cpu byte accesses from a local block array on a hit.
- On a miss, sequences word-wide write-back and fetch transactions on the data_memory handshake.
- Stalls the cpu through BUSYWAIT while memory is busy.

Parameters:
- NUM_BLOCKS, 8, number of cache lines; power of two; INDEX_W = log2(NUM_BLOCKS).
- BLOCK_BYTES, 4, bytes per line; fixed at 4 in this revision, so the offset is 2 bits.
- TAG_W, 8-INDEX_W-2, tag width; derived, not overridden.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RESET  in  1  asynchronous, active-high reset.
- READ  in  1  cpu load request.
- WRITE  in  1  cpu store request.
- ADDRESS  in  8  cpu byte address: {tag, index, offset}.
- WRITEDATA  in  8  cpu store data.
- READDATA  out  8  load data to the cpu.
- BUSYWAIT  out  1  stall to the cpu.
- MEM_READ  out  1  memory block-read request.
- MEM_WRITE  out  1  memory block-write request.
- MEM_ADDRESS  out  6  memory block address.
- MEM_WRITEDATA  out  32  write-back block; byte0 is bits [7:0].
- MEM_READDATA  in  32  fetched block.
- MEM_BUSYWAIT  in  1  memory busy.

Behaviour:
- Storage per line:
  - data[31:0], tag[TAG_W-1:0], valid, dirty.
  - On RESET assertion (async): all valid and dirty bits clear to 0. Data and tag contents are don't-care.
- Reset values of outputs:
  - BUSYWAIT=0, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0.
  - READDATA=8'h00.
  - FSM in IDLE.
- Access and hit:
  - access = READ|WRITE. If both are high, the request is treated as a store.
  - hit = valid[index] && tag[index]==ADDRESS tag. Hit is combinational and evaluated in IDLE only.
- Read hit:
  - READDATA = byte[offset] of the line, combinationally, in the same cycle.
  - BUSYWAIT stays 0, so latency is zero stall cycles.
- Write hit:
  - BUSYWAIT stays 0.
  - At the next posedge, byte[offset] = WRITEDATA and dirty[index] = 1.
- READDATA when no read hit: 8'h00.
- BUSYWAIT = (access && !hit && state==IDLE) || state!=IDLE. It is combinational.
- FSM states: IDLE, WRITE_BACK, FETCH, REFILL.
  - IDLE:
    - On an access miss with dirty[index]=1, go to WRITE_BACK.
    - On an access miss with dirty[index]=0, go to FETCH.
    - Otherwise stay in IDLE.
  - WRITE_BACK:
    - Drives MEM_WRITE=1, MEM_ADDRESS={stored tag, index}, MEM_WRITEDATA=line data.
    - Holds these until a posedge samples MEM_BUSYWAIT=0 after at least one cycle in the state, then goes to FETCH.
  - FETCH:
    - Drives MEM_READ=1, MEM_ADDRESS=ADDRESS[7:2].
    - Leaves on a posedge sampling MEM_BUSYWAIT=0 after at least one cycle in the state, then goes to REFILL.
  - REFILL:
    - All memory requests are deasserted.
    - At the posedge, the line is written from MEM_READDATA with tag from ADDRESS, valid=1, dirty=0.
    - The FSM then returns to IDLE.
- After the refill, the held access re-evaluates as a hit and completes through the normal hit path, including the store.
- MEM_READ and MEM_WRITE are never both high.
- The cpu holds READ/WRITE/ADDRESS/WRITEDATA stable while BUSYWAIT=1. Changes to them during a miss are undefined behaviour and are not checked.
- An access dropped in IDLE does nothing.
- Reset mid-operation:
  - The FSM goes to IDLE immediately and requests deassert asynchronously.
  - The in-flight refill is discarded and all lines are invalidated.
  - A dirty line being written back is lost; this is accepted.
- Index wrap: ADDRESS 0xFC..0xFF maps to index NUM_BLOCKS-1. There is no special case.

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined:
  - Adds outputs HIT_COUNT[15:0] and MISS_COUNT[15:0], both reset async to 0.
  - An access counts once: HIT_COUNT increments on the posedge that completes a first-time hit.
  - MISS_COUNT increments on the IDLE->WRITE_BACK/FETCH transition.
  - The post-refill hit of the same access is not counted.
  - Both counters saturate at 16'hFFFF.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Cold read miss: RESET, READ at ADDRESS=0x05.
  - Expect BUSYWAIT=1, FETCH with MEM_READ=1, MEM_ADDRESS=6'h01.
  - Memory supplies 32'hDDCCBBAA after 5 busy cycles.
  - Then READDATA=8'hBB with BUSYWAIT=0 in the cycle after REFILL.
- Write hit then read: after the above, WRITE 0x05 with WRITEDATA=0x55.
  - Expect no stall and dirty[1]=1.
  - READ 0x05 then returns 0x55 in the same cycle; READ 0x04 returns 0xAA.
- Dirty eviction: WRITE 0x25 (same index 1, tag 1).
  - Expect WRITE_BACK with MEM_WRITE=1, MEM_ADDRESS=6'h01, MEM_WRITEDATA=32'hDDCC55AA.
  - Then FETCH with MEM_ADDRESS=6'h09.
  - After REFILL, the store applies and dirty[1]=1.
- Clean miss skips write-back: READ 0x08 with line 2 invalid.
  - Expect no MEM_WRITE pulse, only FETCH MEM_ADDRESS=6'h02.
- Reset mid-FETCH: assert RESET 2 cycles into FETCH.
  - Expect MEM_READ=0 and BUSYWAIT=0 immediately, without waiting for CLK.
  - A subsequent READ 0x05 misses again.
- DCACHE_STATS_EN: run the cpu loop (repeated store to 0x00, 10 iterations, one cold miss).
  - Expect MISS_COUNT=1, HIT_COUNT=9.
